// File: rtl/hdmi_out_pkg.sv
// Definitions shared by the HDMI output FIFO fill and drain state machines.
package hdmi_out_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        FRAME_END = 2'd2
    } drain_state_e;

    localparam int HALF_WORDS_DEFAULT = 64;

endpackage

// File: rtl/drain_out_reg.sv
// Single-entry pixel output register with first-word-fall-through pop control.
module drain_out_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        streaming,
    input  logic        last_popped,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_dout,
    input  logic        pix_ready,
    output logic        fifo_rd_en,
    output logic        handoff,
    output logic [31:0] pix_data,
    output logic        pix_valid
);

    // Pop only when the register is free or emptying this cycle.
    assign fifo_rd_en = streaming && !fifo_empty && (!pix_valid || pix_ready) && !last_popped;
    assign handoff    = pix_valid && pix_ready;

    // Output register: load on pop, drop valid on a handoff without refill, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_data  <= 32'd0;
            pix_valid <= 1'b0;
        end else if (fifo_rd_en) begin
            pix_data  <= fifo_dout;
            pix_valid <= 1'b1;
        end else if (handoff) begin
            pix_valid <= 1'b0;
        end else begin
            pix_valid <= pix_valid;
        end
    end

endmodule

// File: rtl/drain_fifo_fsm.sv
// Drains one video frame from the line FIFO to the pixel interface.
// Optional underrun counter is built only when DRAIN_UNDERRUN_CNT_EN is defined.
module drain_fifo_fsm
    import hdmi_out_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int HALF_WORDS = HALF_WORDS_DEFAULT
) (
    input  logic        Bus2IP_Clk,
    input  logic        Bus2IP_Reset,
    input  logic        start_drain,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_dout,
    output logic        fifo_rd_en,
    output logic [31:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        line_done,
    output logic        frame_done,
    output logic        half_drained,
    output logic [15:0] underrun_cnt
);

    localparam int XW  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int HCW = (HALF_WORDS > 1) ? $clog2(HALF_WORDS) : 1;
    localparam logic [XW-1:0]  X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]  Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [HCW-1:0] H_LAST = HCW'(HALF_WORDS - 1);

    drain_state_e   state;
    drain_state_e   state_next;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [HCW-1:0] h;
    logic [XW-1:0]  px;
    logic [YW-1:0]  py;
    logic           last_popped;
    logic           handoff;
    logic           line_end_hs;
    logic           frame_end_hs;
    logic           pop_line_end;
    logic           pop_frame_end;
    logic           h_wrap;

    drain_out_reg u_out_reg (
        .clk         (Bus2IP_Clk),
        .rst         (Bus2IP_Reset),
        .streaming   (state == STREAM),
        .last_popped (last_popped),
        .fifo_empty  (fifo_empty),
        .fifo_dout   (fifo_dout),
        .pix_ready   (pix_ready),
        .fifo_rd_en  (fifo_rd_en),
        .handoff     (handoff),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid)
    );

    // x/y follow handoffs; px/py follow pops, one word ahead of x/y.
    assign line_end_hs   = handoff && (x == X_LAST);
    assign frame_end_hs  = line_end_hs && (y == Y_LAST);
    assign pop_line_end  = fifo_rd_en && (px == X_LAST);
    assign pop_frame_end = pop_line_end && (py == Y_LAST);
    assign h_wrap        = fifo_rd_en && (h == H_LAST);

    // State register.
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start_drain is only looked at in IDLE so a frame never aborts.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      state_next = start_drain ? STREAM : IDLE;
            STREAM:    state_next = frame_end_hs ? FRAME_END : STREAM;
            FRAME_END: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Position counters and the half-FIFO pop counter.
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            x           <= '0;
            y           <= '0;
            h           <= '0;
            px          <= '0;
            py          <= '0;
            last_popped <= 1'b0;
        end else if (state == IDLE) begin
            x           <= '0;
            y           <= '0;
            h           <= '0;
            px          <= '0;
            py          <= '0;
            last_popped <= 1'b0;
        end else begin
            if (handoff) begin
                x <= (x == X_LAST) ? '0 : x + XW'(1);
                if (x == X_LAST) begin
                    y <= (y == Y_LAST) ? '0 : y + YW'(1);
                end
            end
            if (fifo_rd_en) begin
                px <= (px == X_LAST) ? '0 : px + XW'(1);
                if (px == X_LAST) begin
                    py <= (py == Y_LAST) ? '0 : py + YW'(1);
                end
                // Popping a line's last word commits its line_done, so h restarts there.
                h <= (pop_line_end || h_wrap) ? '0 : h + HCW'(1);
            end
            if (pop_frame_end) begin
                last_popped <= 1'b1;
            end
        end
    end

    // Feedback pulses to the fill FSM; line_done wins over a coincident half request.
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            line_done    <= 1'b0;
            frame_done   <= 1'b0;
            half_drained <= 1'b0;
        end else begin
            line_done    <= line_end_hs;
            frame_done   <= frame_end_hs;
            half_drained <= h_wrap && !pop_line_end;
        end
    end

`ifdef DRAIN_UNDERRUN_CNT_EN
    logic underrun;
    assign underrun = (state == STREAM) && fifo_empty && !pix_valid && !last_popped;

    // Saturating starvation counter, cleared only by reset.
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            underrun_cnt <= 16'd0;
        end else if (underrun && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end else begin
            underrun_cnt <= underrun_cnt;
        end
    end
`else
    assign underrun_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_drain_fifo_fsm.sv
// Self-checking bench for drain_fifo_fsm with an 8x2 frame and 4-word half requests.
module tb_drain_fifo_fsm;
    import hdmi_out_pkg::*;

    localparam int H  = 8;
    localparam int V  = 2;
    localparam int HW = 4;
    localparam int NW = H * V;
    localparam int NV = 19;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_drain;
    logic        fifo_empty;
    logic [31:0] fifo_dout;
    logic        fifo_rd_en;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        line_done;
    logic        frame_done;
    logic        half_drained;
    logic [15:0] underrun_cnt;

    logic [31:0] mem [0:NW-1];
    int          rd_ptr;
    logic        gate;
    logic [31:0] got [$];
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic        start;
        logic [31:0] data;
        logic        valid;
        logic        rd;
        logic        line;
        logic        frame;
        logic        half;
    } vec_t;
    vec_t tbl [NV];

    assign fifo_empty = gate || (rd_ptr >= NW);
    assign fifo_dout  = (rd_ptr < NW) ? mem[rd_ptr[3:0]] : 32'd0;

    drain_fifo_fsm #(.H_ACTIVE(H), .V_ACTIVE(V), .HALF_WORDS(HW)) dut (
        .Bus2IP_Clk   (clk),
        .Bus2IP_Reset (rst),
        .start_drain  (start_drain),
        .fifo_empty   (fifo_empty),
        .fifo_dout    (fifo_dout),
        .fifo_rd_en   (fifo_rd_en),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .line_done    (line_done),
        .frame_done   (frame_done),
        .half_drained (half_drained),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: record any handoff, advance the FIFO model on a pop, settle outputs.
    task automatic cycle();
        logic rd;
        #1;
        rd = fifo_rd_en;
        if (pix_valid && pix_ready) got.push_back(pix_data);
        @(posedge clk);
        #1;
        if (rd) rd_ptr = rd_ptr + 1;
        #1;
    endtask

    task automatic load_fifo();
        for (int i = 0; i < NW; i++) mem[i] = 32'(i);
        rd_ptr = 0;
        gate   = 1'b0;
        got.delete();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        start_drain = 1'b0;
        pix_ready   = 1'b1;
        load_fifo();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic start_frame();
        start_drain = 1'b1;
        cycle();
        start_drain = 1'b0;
    endtask

    task automatic wait_word(input string tag, input logic [31:0] word);
        bit found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            if (pix_valid && pix_data == word) found = 1'b1;
            else cycle();
        end
        check({tag, "_reach"}, 32'(found), 32'd1);
    endtask

    task automatic run_frame(input string tag, input int bound);
        bit done = 1'b0;
        for (int n = 0; n < bound && !done; n++) begin
            cycle();
            if (frame_done) done = 1'b1;
        end
        check({tag, "_frame_done"}, 32'(done), 32'd1);
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, 32'(got.size()), 32'(NW));
        for (int i = 0; i < got.size() && i < NW; i++)
            check($sformatf("%s_word%0d", tag, i), got[i], 32'(i));
    endtask

    initial begin
        // Ready held high, start for one cycle: word k shows after edge k+1.
        for (int s = 0; s < NV; s++) begin
            tbl[s].start = (s == 0);
            tbl[s].valid = (s >= 1 && s <= 16);
            tbl[s].data  = (s == 0) ? 32'd0 : (s <= 16) ? 32'(s - 1) : 32'd15;
            tbl[s].rd    = (s <= 15);
            tbl[s].line  = (s == 9 || s == 17);
            tbl[s].frame = (s == 17);
            tbl[s].half  = (s == 4 || s == 12);
        end

        do_reset();
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_data", pix_data, 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_pulses", {29'd0, line_done, frame_done, half_drained}, 32'd0);
        check("rst_underrun", 32'(underrun_cnt), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));

        for (int s = 0; s < NV; s++) begin
            start_drain = tbl[s].start;
            cycle();
            check($sformatf("frame[%0d].valid", s), 32'(pix_valid), 32'(tbl[s].valid));
            check($sformatf("frame[%0d].data", s), pix_data, tbl[s].data);
            check($sformatf("frame[%0d].rd_en", s), 32'(fifo_rd_en), 32'(tbl[s].rd));
            check($sformatf("frame[%0d].line", s), 32'(line_done), 32'(tbl[s].line));
            check($sformatf("frame[%0d].frame", s), 32'(frame_done), 32'(tbl[s].frame));
            check($sformatf("frame[%0d].half", s), 32'(half_drained), 32'(tbl[s].half));
        end
        check("frame_idle", 32'(dut.state), 32'(IDLE));
        check_stream("frame");

        // Backpressure on word 5.
        do_reset();
        start_frame();
        wait_word("bp", 32'd5);
        pix_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("bp_hold%0d_data", i), pix_data, 32'd5);
            check($sformatf("bp_hold%0d_valid", i), 32'(pix_valid), 32'd1);
            check($sformatf("bp_hold%0d_rd_en", i), 32'(fifo_rd_en), 32'd0);
        end
        pix_ready = 1'b1;
        run_frame("bp", 40);
        check_stream("bp");

        // FIFO starved right after word 3 is shown: one handoff cycle then five starved cycles.
        do_reset();
        start_frame();
        wait_word("ur", 32'd3);
        gate = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        check("ur_valid", 32'(pix_valid), 32'd0);
        check("ur_x", 32'(dut.x), 32'd4);
`ifdef DRAIN_UNDERRUN_CNT_EN
        check("ur_cnt", 32'(underrun_cnt), 32'd5);
`else
        check("ur_cnt", 32'(underrun_cnt), 32'd0);
`endif
        gate = 1'b0;
        run_frame("ur", 40);
        check_stream("ur");
`ifdef DRAIN_UNDERRUN_CNT_EN
        check("ur_cnt_end", 32'(underrun_cnt), 32'd5);
`else
        check("ur_cnt_end", 32'(underrun_cnt), 32'd0);
`endif

        // Reset asserted while word 10 is held, then a fresh frame.
        do_reset();
        start_frame();
        wait_word("mr", 32'd10);
        rst = 1'b1;
        #1;
        check("mr_valid", 32'(pix_valid), 32'd0);
        check("mr_data", pix_data, 32'd0);
        check("mr_rd_en", 32'(fifo_rd_en), 32'd0);
        check("mr_pulses", {29'd0, line_done, frame_done, half_drained}, 32'd0);
        check("mr_underrun", 32'(underrun_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        load_fifo();
        #1;
        start_frame();
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                cycle();
                if (line_done) seen = 1'b1;
            end
            check("mr_line_seen", 32'(seen), 32'd1);
            check("mr_line_after", 32'(got.size()), 32'(H));
        end
        run_frame("mr", 40);
        check_stream("mr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/drain_fifo_fsm.md
DRAIN_FIFO_FSM -- requirements
Module: drain_fifo_fsm

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, giving active pixels per line (one 32-bit word per pixel).
REQ-002 The block SHALL have parameter V_ACTIVE, default 480, giving active lines per frame.
REQ-003 The block SHALL have parameter HALF_WORDS, default 64, giving the FIFO words per half-FIFO refill request.
REQ-004 The block SHALL have the port Bus2IP_Clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have the port Bus2IP_Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have the port start_drain, input, 1 bit: level signal that arms draining of one frame.
REQ-007 The block SHALL have the FIFO-side ports fifo_empty (input, 1), fifo_dout (input, 32) and fifo_rd_en (output, 1); the FIFO is first-word-fall-through, fifo_dout is valid while !fifo_empty, and fifo_rd_en pops one word.
REQ-008 The block SHALL have the pixel-side ports pix_data (output, 32), pix_valid (output, 1) and pix_ready (input, 1).
REQ-009 The block SHALL have the feedback ports line_done (output, 1, hsync to the fill FSM), frame_done (output, 1, vsync to the fill FSM) and half_drained (output, 1, the half_full request to the fill FSM); each is a one-cycle pulse.
REQ-010 The block SHALL have the port underrun_cnt, output, 16 bits.

Function
REQ-011 The state machine SHALL have the states IDLE, STREAM and FRAME_END; IDLE goes to STREAM when start_drain=1; STREAM goes to FRAME_END on the handoff of the last pixel of line V_ACTIVE-1; FRAME_END goes to IDLE after one cycle.
REQ-012 A single output register SHALL hold pix_data/pix_valid, and fifo_rd_en SHALL equal (state==STREAM) && !fifo_empty && (!pix_valid || pix_ready) && !last_word_popped, where last_word_popped means the frame's final word is already in the register.
REQ-013 A pop SHALL load the register with fifo_dout on the next edge with pix_valid=1; a handoff (pix_valid && pix_ready) with no pop SHALL clear pix_valid; pix_data SHALL be held while pix_valid && !pix_ready.
REQ-014 Counters x (0..H_ACTIVE-1) and y (0..V_ACTIVE-1) SHALL advance on each handoff; x wraps to 0 and increments y at H_ACTIVE-1.
REQ-015 line_done SHALL pulse in the cycle after the handoff at x=H_ACTIVE-1, for every line including the last.
REQ-016 frame_done SHALL pulse in the FRAME_END cycle, i.e. in the same cycle as the final line_done.
REQ-017 A counter h SHALL count pops modulo HALF_WORDS, and half_drained SHALL pulse in the cycle after h wraps.
REQ-018 h SHALL clear whenever line_done is generated, and the half_drained pulse SHALL be suppressed in that cycle, so that line_done takes priority over half_drained.
REQ-019 The x, y and h counters SHALL clear on entry to IDLE.
REQ-020 Deasserting start_drain mid-frame SHALL NOT abort the frame.
REQ-021 An underrun cycle SHALL be counted when state==STREAM && fifo_empty && !pix_valid and the frame is not complete.
REQ-022 Counter widths SHALL be $clog2 of their range, and compares SHALL use the parameter minus 1.

Reset
REQ-023 Bus2IP_Reset SHALL asynchronously force: state IDLE; x, y and h to 0; pix_valid, fifo_rd_en, line_done, frame_done and half_drained to 0; pix_data to 0; underrun_cnt to 0.
REQ-024 Reset asserted mid-frame SHALL discard any held pixel, and the next frame SHALL start at x=0, y=0.

Configuration
REQ-025 With the macro DRAIN_UNDERRUN_CNT_EN defined, underrun_cnt SHALL increment on each underrun cycle, saturate at 16'hFFFF and clear only on reset.
REQ-026 Without DRAIN_UNDERRUN_CNT_EN, underrun_cnt SHALL be constant 0 and no counter logic SHALL be built.

Structure
REQ-027 The state encodings (IDLE, STREAM, FRAME_END) and the default HALF_WORDS constant SHALL live in the shared package hdmi_out_pkg, which is also used by the fill FSM.
REQ-028 The output register and pop logic SHALL be the sub-module drain_out_reg; the counters and state machine SHALL remain in the top level.

Verification
REQ-029 The bench SHALL use H_ACTIVE=8, V_ACTIVE=2 and HALF_WORDS=4 for all scenarios below.
REQ-030 Full frame: FIFO preloaded with words 0..15, pix_ready=1, start pulse -> pix_data 0..15 on consecutive cycles; line_done after words 7 and 15; frame_done with the second line_done; state returns to IDLE.
REQ-031 Half pulse: same stimulus -> half_drained pulses after pops 4 and 12 only; the pulse at pops 8 and 16 is suppressed by line_done.
REQ-032 Backpressure: pix_ready=0 for 3 cycles at word 5 -> pix_data=5 held stable, fifo_rd_en=0, no word lost or duplicated.
REQ-033 Underrun: FIFO empty for 5 cycles mid-line with the macro defined -> underrun_cnt=5 and x unchanged; without the macro -> underrun_cnt=0.
REQ-034 Mid-frame reset: Bus2IP_Reset asserted at word 10 -> all outputs 0 immediately; the next start restarts at x=0 with line_done after 8 pixels.
